four_three_demux_bank: RTL and testbench

Registered 1-to-8 distributor for 4-bit values. It is the write-side counterpart of the ALU's 8-to-1 result selector. A source offers one 4-bit word plus a 3-bit destination index over a valid/ready handshake. The block stores the word into one of eight 4-bit registers and pulses a one-hot write strobe. A burst mode writes consecutive words to consecutive destinations, wrapping modulo 8.

---
 rtl/four_three_demux_bank_pkg.sv | 12 +
 rtl/four_three_demux_bank_decoder.sv | 19 +
 rtl/four_three_demux_bank.sv | 103 ++++++++++
 tb/tb_four_three_demux_bank.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/four_three_demux_bank_pkg.sv
// rtl/four_three_demux_bank_pkg.sv - shared widths and FSM state encodings for the demux bank
package four_three_demux_bank_pkg;

    localparam int DEF_WIDTH = 4;
    localparam int DEF_SEL_W = 3;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_t;

endpackage

// File: rtl/four_three_demux_bank_decoder.sv
// rtl/four_three_demux_bank_decoder.sv - SEL_W-to-2**SEL_W one-hot decoder with enable
module three_eight_decoder
    import four_three_demux_bank_pkg::*;
#(
    parameter int SEL_W = DEF_SEL_W
) (
    input  logic                  en,
    input  logic [SEL_W-1:0]      sel,
    output logic [(1<<SEL_W)-1:0] onehot
);

    always_comb begin
        onehot = '0;
        if (en) begin
            onehot[sel] = 1'b1;
        end
    end

endmodule

// File: rtl/four_three_demux_bank.sv
// rtl/four_three_demux_bank.sv - registered 1-to-8 distributor of 4-bit words with wrapping burst mode
module four_three_demux_bank
    import four_three_demux_bank_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int SEL_W = DEF_SEL_W,
    parameter int NUM   = 1 << SEL_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_data,
    input  logic [SEL_W-1:0]     in_sel,
    input  logic                 burst,
    input  logic [SEL_W-1:0]     burst_len,
    output logic [NUM*WIDTH-1:0] out_q,
    output logic [NUM-1:0]       out_wr,
    output logic                 busy,
    output logic                 done
);

    localparam logic [SEL_W-1:0] ONE = 1;

    state_t                         state, state_nxt;
    logic [SEL_W-1:0]               ptr, ptr_nxt;
    logic [SEL_W-1:0]               remaining, remaining_nxt;
    logic [NUM-1:0][WIDTH-1:0]      regs;
    logic [NUM-1:0]                 wr_en;
    logic [SEL_W-1:0]               wr_idx;
    logic                           accept;
    logic                           last;

    assign in_ready = !clear;
    assign accept   = in_valid && in_ready;
    assign busy     = (state == ST_BURST);
    assign out_q    = regs;
    assign wr_idx   = (state == ST_IDLE) ? in_sel : ptr;

    three_eight_decoder #(.SEL_W(SEL_W)) u_dec (
        .en     (accept),
        .sel    (wr_idx),
        .onehot (wr_en)
    );

    always_comb begin
        state_nxt     = state;
        ptr_nxt       = ptr;
        remaining_nxt = remaining;
        last          = 1'b0;
        if (accept) begin
            if (state == ST_IDLE) begin
                if (!burst || burst_len == '0) begin
                    last = 1'b1;
                end else begin
                    ptr_nxt       = in_sel + ONE;
                    remaining_nxt = burst_len;
                    state_nxt     = ST_BURST;
                end
            end else begin
                ptr_nxt       = ptr + ONE;
                remaining_nxt = remaining - ONE;
                if (remaining == ONE) begin
                    last      = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            ptr       <= '0;
            remaining <= '0;
            out_wr    <= '0;
            done      <= 1'b0;
        end else begin
            state     <= state_nxt;
            ptr       <= ptr_nxt;
            remaining <= remaining_nxt;
            out_wr    <= wr_en;
            done      <= last;
        end
    end

    // clear wins over any write; wr_en is already zero then since in_ready is low
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs <= '0;
        end else if (clear) begin
            regs <= '0;
        end else begin
            for (int i = 0; i < NUM; i++) begin
                if (wr_en[i]) begin
                    regs[i] <= in_data;
                end
            end
        end
    end

endmodule

// File: tb/tb_four_three_demux_bank.sv
// tb/tb_four_three_demux_bank.sv - table-driven self-checking bench for four_three_demux_bank
module tb_four_three_demux_bank;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clear;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_data;
    logic [2:0]  in_sel;
    logic        burst;
    logic [2:0]  burst_len;
    logic [31:0] out_q;
    logic [7:0]  out_wr;
    logic        busy;
    logic        done;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        string       name;
        logic        rst_n;
        logic        clear;
        logic        valid;
        logic [3:0]  data;
        logic [2:0]  sel;
        logic        burst;
        logic [2:0]  len;
        logic [31:0] exp_q;
        logic [7:0]  exp_wr;
        logic        exp_busy;
        logic        exp_done;
        logic        exp_ready;
    } vec_t;

    vec_t vecs[$];

    four_three_demux_bank dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .burst     (burst),
        .burst_len (burst_len),
        .out_q     (out_q),
        .out_wr    (out_wr),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input string name, input logic r, input logic c, input logic v,
                       input logic [3:0] d, input logic [2:0] s, input logic b, input logic [2:0] l,
                       input logic [31:0] q, input logic [7:0] wr, input logic bz,
                       input logic dn, input logic rdy);
        vec_t t;
        t.name = name; t.rst_n = r; t.clear = c; t.valid = v; t.data = d; t.sel = s;
        t.burst = b; t.len = l; t.exp_q = q; t.exp_wr = wr; t.exp_busy = bz;
        t.exp_done = dn; t.exp_ready = rdy;
        vecs.push_back(t);
    endtask

    task automatic check_all(input string name, input logic [31:0] q, input logic [7:0] wr,
                             input logic bz, input logic dn, input logic rdy);
        chk({name, ".out_q"},    out_q,            q);
        chk({name, ".out_wr"},   {24'h0, out_wr},  {24'h0, wr});
        chk({name, ".busy"},     {31'h0, busy},    {31'h0, bz});
        chk({name, ".done"},     {31'h0, done},    {31'h0, dn});
        chk({name, ".in_ready"}, {31'h0, in_ready}, {31'h0, rdy});
    endtask

    task automatic drive(input logic r, input logic c, input logic v, input logic [3:0] d,
                         input logic [2:0] s, input logic b, input logic [2:0] l);
        rst_n = r; clear = c; in_valid = v; in_data = d; in_sel = s; burst = b; burst_len = l;
    endtask

    initial begin
        drive(1'b0, 1'b0, 1'b1, 4'h5, 3'd5, 1'b0, 3'd0);

        //   name        rst clr val data sel brst len  exp_q          wr     busy done rdy
        add("rst0",      0,  0,  1,  4'h5, 5, 0, 0, 32'h0000_0000, 8'h00, 0, 0, 1);
        add("rst1",      0,  0,  1,  4'h5, 5, 0, 0, 32'h0000_0000, 8'h00, 0, 0, 1);
        add("rel",       1,  0,  0,  4'h0, 0, 0, 0, 32'h0000_0000, 8'h00, 0, 0, 1);
        add("single",    1,  0,  1,  4'hA, 5, 0, 0, 32'h00A0_0000, 8'h20, 0, 1, 1);
        add("single_q",  1,  0,  0,  4'h0, 0, 0, 0, 32'h00A0_0000, 8'h00, 0, 0, 1);
        add("wrap0",     1,  0,  1,  4'h1, 6, 1, 3, 32'h01A0_0000, 8'h40, 1, 0, 1);
        add("wrap1",     1,  0,  1,  4'h2, 0, 0, 0, 32'h21A0_0000, 8'h80, 1, 0, 1);
        add("wrap2",     1,  0,  1,  4'h3, 4, 1, 1, 32'h21A0_0003, 8'h01, 1, 0, 1);
        add("wrap3",     1,  0,  1,  4'h4, 0, 0, 0, 32'h21A0_0043, 8'h02, 0, 1, 1);
        add("wrap_q",    1,  0,  0,  4'h0, 0, 0, 0, 32'h21A0_0043, 8'h00, 0, 0, 1);
        add("gap0",      1,  0,  1,  4'h9, 0, 1, 2, 32'h21A0_0049, 8'h01, 1, 0, 1);
        add("gap1",      1,  0,  0,  4'h0, 0, 0, 0, 32'h21A0_0049, 8'h00, 1, 0, 1);
        add("gap2",      1,  0,  0,  4'h0, 0, 0, 0, 32'h21A0_0049, 8'h00, 1, 0, 1);
        add("gap3",      1,  0,  0,  4'h0, 0, 0, 0, 32'h21A0_0049, 8'h00, 1, 0, 1);
        add("gapclr",    1,  1,  1,  4'hF, 5, 0, 0, 32'h0000_0000, 8'h00, 1, 0, 0);
        add("gap4",      1,  0,  1,  4'h7, 5, 0, 0, 32'h0000_0070, 8'h02, 1, 0, 1);
        add("gap5",      1,  0,  1,  4'h8, 5, 0, 0, 32'h0000_0870, 8'h04, 0, 1, 1);
        add("gap_q",     1,  0,  0,  4'h0, 0, 0, 0, 32'h0000_0870, 8'h00, 0, 0, 1);
        add("idleclr",   1,  1,  1,  4'hE, 3, 0, 0, 32'h0000_0000, 8'h00, 0, 0, 0);
        add("full0",     1,  0,  1,  4'h0, 2, 1, 7, 32'h0000_0000, 8'h04, 1, 0, 1);
        add("full1",     1,  0,  1,  4'h1, 0, 0, 0, 32'h0000_1000, 8'h08, 1, 0, 1);
        add("full2",     1,  0,  1,  4'h2, 0, 0, 0, 32'h0002_1000, 8'h10, 1, 0, 1);
        add("full3",     1,  0,  1,  4'h3, 0, 0, 0, 32'h0032_1000, 8'h20, 1, 0, 1);
        add("full4",     1,  0,  1,  4'h4, 0, 0, 0, 32'h0432_1000, 8'h40, 1, 0, 1);
        add("full5",     1,  0,  1,  4'h5, 0, 0, 0, 32'h5432_1000, 8'h80, 1, 0, 1);
        add("full6",     1,  0,  1,  4'h6, 0, 0, 0, 32'h5432_1006, 8'h01, 1, 0, 1);
        add("full7",     1,  0,  1,  4'h7, 0, 0, 0, 32'h5432_1076, 8'h02, 0, 1, 1);
        add("full_q",    1,  0,  0,  4'h0, 0, 0, 0, 32'h5432_1076, 8'h00, 0, 0, 1);

        foreach (vecs[i]) begin
            drive(vecs[i].rst_n, vecs[i].clear, vecs[i].valid, vecs[i].data,
                  vecs[i].sel, vecs[i].burst, vecs[i].len);
            @(posedge clk);
            #1;
            check_all(vecs[i].name, vecs[i].exp_q, vecs[i].exp_wr,
                      vecs[i].exp_busy, vecs[i].exp_done, vecs[i].exp_ready);
        end

        // Reset mid-burst: two of four words, then asynchronous reset between edges
        drive(1'b1, 1'b0, 1'b1, 4'h1, 3'd0, 1'b1, 3'd3);
        @(posedge clk); #1;
        check_all("mid0", 32'h5432_1071, 8'h01, 1'b1, 1'b0, 1'b1);
        drive(1'b1, 1'b0, 1'b1, 4'h2, 3'd0, 1'b0, 3'd0);
        @(posedge clk); #1;
        check_all("mid1", 32'h5432_1021, 8'h02, 1'b1, 1'b0, 1'b1);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        check_all("midrst", 32'h0000_0000, 8'h00, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        drive(1'b1, 1'b0, 1'b1, 4'h9, 3'd3, 1'b0, 3'd0);
        @(posedge clk); #1;
        check_all("after_rst", 32'h0000_9000, 8'h08, 1'b0, 1'b1, 1'b1);
        in_valid = 1'b0;
        @(posedge clk); #1;
        check_all("after_rst_q", 32'h0000_9000, 8'h00, 1'b0, 1'b0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
